fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 5 +
 rtl/rr_select.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state and packet-counter width for the FIFO write arbiter
package fifo_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick, first eligible index above last_owner
module rr_select #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_owner,
  output logic [W-1:0] winner,
  output logic         any_valid
);
  int idx;
  // Walk offsets from farthest to nearest so the nearest eligible index wins
  always_comb begin
    winner = '0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % N;
      if (eligible[idx]) winner = W'(idx);
    end
    any_valid = |eligible;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter feeding one async FIFO write port
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_mask,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic [PKT_CNT_W-1:0]          pkt_cnt
);
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d, last_q, last_d, winner;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic any_valid;
  rr_select #(.N(NUM_REQ)) u_rr (
    .eligible  (req_valid & req_mask),
    .last_owner(last_q),
    .winner    (winner),
    .any_valid (any_valid)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    req_ready = '0;
    fifo_w_en = 1'b0;
    fifo_wdata = '0;
    if (state_q == IDLE) begin
      state_d = any_valid ? LOCK : IDLE;
      grant_d = any_valid ? winner : grant_q;
    end else begin
      req_ready[grant_q] = !fifo_full;
      fifo_w_en = req_valid[grant_q] & !fifo_full;
      fifo_wdata = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      // Only a transferred last beat releases the lock
      if (fifo_w_en && req_last[grant_q]) begin
        state_d = IDLE;
        last_d = grant_q;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = (state_q == LOCK);
  assign grant_id = grant_q;
  assign pkt_cnt = cnt_q;
endmodule
